// File: rtl/tt_um_oconnt_counter_ctrl.sv
// rtl/tt_um_oconnt_counter_ctrl.sv - command-sequenced 8-bit counter with limit, direction, wrap/one-shot
// Optional prescaler (presc/div registers, LOAD_PRESC) enabled by COUNTER_CTRL_PRESCALE_EN.
module tt_um_oconnt_counter_ctrl (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_LOAD_COUNT = 3'd1;
  localparam logic [2:0] OP_LOAD_LIMIT = 3'd2;
  localparam logic [2:0] OP_LOAD_PRESC = 3'd3;
  localparam logic [2:0] OP_START      = 3'd4;
  localparam logic [2:0] OP_STOP       = 3'd5;
  localparam logic [2:0] OP_CLEAR      = 3'd6;
  localparam logic [2:0] OP_STEP       = 3'd7;

  state_t     state, state_next;
  logic [7:0] count, count_next;
  logic [7:0] limit, limit_next;
  logic       dir, dir_next;
  logic       mode, mode_next;
  logic       wrap_flag, wrap_next;
  logic       tick;
  logic [2:0] cmd;
  logic       suppress;
  logic       at_end;
  logic [7:0] status;

  logic       unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[6]};

  assign cmd = ui_in[3] ? ui_in[2:0] : OP_NOP;

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [7:0] presc, presc_next;
  logic [7:0] div, div_next;

  assign tick = (state == RUN) && (div == presc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= 8'd0;
      div   <= 8'd0;
    end else begin
      presc <= presc_next;
      div   <= div_next;
    end
  end

  always_comb begin
    presc_next = presc;
    div_next   = div;
    if (state == RUN) begin
      div_next = tick ? 8'd0 : div + 8'd1;
    end
    if (cmd == OP_LOAD_PRESC) begin
      presc_next = uio_in;
    end
    if (cmd == OP_START || cmd == OP_STOP) begin
      div_next = 8'd0;
    end
  end
`else
  assign tick = (state == RUN);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= 8'd0;
      limit     <= 8'hFF;
      dir       <= 1'b0;
      mode      <= 1'b0;
      wrap_flag <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      limit     <= limit_next;
      dir       <= dir_next;
      mode      <= mode_next;
      wrap_flag <= wrap_next;
    end
  end

  // Commands that rewrite count or leave RUN take the cycle; the tick's update is dropped.
  assign suppress = (cmd == OP_LOAD_COUNT) || (cmd == OP_START) ||
                    (cmd == OP_STOP) || (cmd == OP_CLEAR);
  assign at_end   = dir ? (count == 8'd0) : (count == limit);

  always_comb begin
    state_next = state;
    count_next = count;
    limit_next = limit;
    dir_next   = dir;
    mode_next  = mode;
    wrap_next  = wrap_flag;

    if (tick && !suppress) begin
      if (!at_end) begin
        count_next = dir ? count - 8'd1 : count + 8'd1;
      end else if (mode) begin
        state_next = DONE;
      end else begin
        count_next = dir ? limit : 8'd0;
        wrap_next  = 1'b1;
      end
    end

    case (cmd)
      OP_LOAD_COUNT: count_next = uio_in;
      OP_LOAD_LIMIT: limit_next = uio_in;
      OP_START: begin
        dir_next   = ui_in[4];
        mode_next  = ui_in[5];
        wrap_next  = 1'b0;
        state_next = RUN;
      end
      OP_STOP: state_next = IDLE;
      OP_CLEAR: begin
        count_next = 8'd0;
        wrap_next  = 1'b0;
        if (state == DONE) begin
          state_next = IDLE;
        end
      end
      OP_STEP: begin
        if (state == IDLE) begin
          count_next = dir ? count - 8'd1 : count + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign status  = {state == RUN, state == DONE, wrap_flag, dir, mode, tick, 2'b00};
  assign uo_out  = ui_in[7] ? status : count;
  assign uio_out = 8'd0;
  assign uio_oe  = 8'd0;

endmodule

// File: tb/tb_tt_um_oconnt_counter_ctrl.sv
// tb/tb_tt_um_oconnt_counter_ctrl.sv - directed bench with per-cycle reference model for the counter controller
`timescale 1ns/1ps
module tb_tt_um_oconnt_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int failures = 0;
  bit view_bit = 1'b0;

  tt_um_oconnt_counter_ctrl dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers, running/done flags instead of a state code.
  int m_count = 0;
  int m_limit = 255;
  int m_presc = 0;
  int m_div = 0;
  bit m_run = 0, m_done = 0, m_wrap = 0, m_dir = 0, m_mode = 0;
  int op_s;
  bit t_s, idle_s, done_s, end_s;

  function automatic bit m_tick();
    return m_run && (m_div == m_presc);
  endfunction

  function automatic logic [7:0] exp_out();
    logic [7:0] st;
    st = {m_run, m_done, m_wrap, m_dir, m_mode, m_tick(), 2'b00};
    return ui_in[7] ? st : 8'(m_count);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count = 0; m_limit = 255; m_presc = 0; m_div = 0;
      m_run = 0; m_done = 0; m_wrap = 0; m_dir = 0; m_mode = 0;
    end else begin
      op_s   = ui_in[3] ? int'(ui_in[2:0]) : 0;
      t_s    = m_tick();
      idle_s = !m_run && !m_done;
      done_s = m_done;
      if (m_run) m_div = t_s ? 0 : m_div + 1;
      if (t_s && !(op_s inside {1, 4, 5, 6})) begin
        end_s = m_dir ? (m_count == 0) : (m_count == m_limit);
        if (!end_s) m_count = (m_count + (m_dir ? 255 : 1)) % 256;
        else if (m_mode) begin m_run = 0; m_done = 1; end
        else begin m_count = m_dir ? m_limit : 0; m_wrap = 1; end
      end
      case (op_s)
        1: m_count = int'(uio_in);
        2: m_limit = int'(uio_in);
        3: begin
`ifdef COUNTER_CTRL_PRESCALE_EN
          m_presc = int'(uio_in);
`endif
        end
        4: begin
          m_dir = ui_in[4]; m_mode = ui_in[5];
          m_div = 0; m_wrap = 0; m_run = 1; m_done = 0;
        end
        5: begin m_run = 0; m_done = 0; m_div = 0; end
        6: begin m_count = 0; m_wrap = 0; if (done_s) m_done = 0; end
        7: if (idle_s) m_count = (m_count + (m_dir ? 255 : 1)) % 256;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    check("uo_out_model", uo_out, exp_out());
    check("uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h00);
  end

  // One-cycle command pulse; returns 3ns after the edge that executed it.
  task automatic cmd(input logic [2:0] op, input bit d, input bit m, input logic [7:0] data);
    @(posedge clk); #2;
    ui_in  = {view_bit, 1'b0, m, d, 1'b1, op};
    uio_in = data;
    @(posedge clk); #2;
    ui_in  = {view_bit, 7'd0};
    #1;
  endtask

  task automatic step();
    @(posedge clk); #3;
  endtask

  task automatic peek_status(input string name, input logic [7:0] exp);
    ui_in[7] = 1'b1; #1;
    check(name, uo_out, exp);
    ui_in[7] = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3;
    check("reset_count", uo_out, 8'h00);
    peek_status("reset_status", 8'h00);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;

    // free-running up/wrap, presc 0
    cmd(3'd4, 1'b0, 1'b0, 8'd0);
    check("run_c0", uo_out, 8'd0);
    step(); check("run_c1", uo_out, 8'd1);
    step(); check("run_c2", uo_out, 8'd2);
    repeat (254) step();
    check("wrap_c0", uo_out, 8'd0);
    peek_status("wrap_status", 8'hA4);

    // one-shot up to limit 5
    cmd(3'd5, 1'b0, 1'b0, 8'd0);
    cmd(3'd2, 1'b0, 1'b0, 8'd5);
    cmd(3'd6, 1'b0, 1'b0, 8'd0);
    cmd(3'd4, 1'b0, 1'b1, 8'd0);
    check("os_c0", uo_out, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      step(); check("os_cnt", uo_out, 8'(k));
    end
    step();
    peek_status("os_done_status", 8'h48);
    repeat (5) step();
    check("os_hold", uo_out, 8'd5);
    cmd(3'd7, 1'b0, 1'b0, 8'd0);
    check("step_in_done", uo_out, 8'd5);

    // down/wrap from 3 with limit 9
    cmd(3'd5, 1'b0, 1'b0, 8'd0);
    cmd(3'd1, 1'b0, 1'b0, 8'd3);
    cmd(3'd2, 1'b0, 1'b0, 8'd9);
    cmd(3'd4, 1'b1, 1'b0, 8'd0);
    check("dn_c3", uo_out, 8'd3);
    step(); check("dn_c2", uo_out, 8'd2);
    step(); check("dn_c1", uo_out, 8'd1);
    step(); check("dn_c0", uo_out, 8'd0);
    step(); check("dn_c9", uo_out, 8'd9);
    step(); check("dn_c8", uo_out, 8'd8);

    // prescaler 2
    cmd(3'd5, 1'b0, 1'b0, 8'd0);
    cmd(3'd6, 1'b0, 1'b0, 8'd0);
    cmd(3'd2, 1'b0, 1'b0, 8'hFF);
    cmd(3'd3, 1'b0, 1'b0, 8'd2);
    cmd(3'd4, 1'b0, 1'b0, 8'd0);
    check("ps_c0", uo_out, 8'd0);
    for (int k = 1; k <= 9; k++) begin
      step();
`ifdef COUNTER_CTRL_PRESCALE_EN
      check("ps_cnt", uo_out, 8'(k / 3));
`else
      check("ps_cnt", uo_out, 8'(k));
`endif
    end
    cmd(3'd5, 1'b0, 1'b0, 8'd0);
    cmd(3'd3, 1'b0, 1'b0, 8'd0);

    // limit 0, up/wrap
    cmd(3'd2, 1'b0, 1'b0, 8'd0);
    cmd(3'd6, 1'b0, 1'b0, 8'd0);
    cmd(3'd4, 1'b0, 1'b0, 8'd0);
    check("l0_c0", uo_out, 8'd0);
    step(); check("l0_c0b", uo_out, 8'd0);
    peek_status("l0_status", 8'hA4);

    // STEP down in IDLE
    cmd(3'd4, 1'b1, 1'b0, 8'd0);
    cmd(3'd5, 1'b0, 1'b0, 8'd0);
    cmd(3'd1, 1'b0, 1'b0, 8'd1);
    cmd(3'd7, 1'b0, 1'b0, 8'd0); check("step_0", uo_out, 8'd0);
    cmd(3'd7, 1'b0, 1'b0, 8'd0); check("step_ff", uo_out, 8'hFF);
    cmd(3'd7, 1'b0, 1'b0, 8'd0); check("step_fe", uo_out, 8'hFE);

    // LOAD_LIMIT on a tick compares against the old limit
    cmd(3'd2, 1'b0, 1'b0, 8'hFF);
    cmd(3'd6, 1'b0, 1'b0, 8'd0);
    cmd(3'd4, 1'b0, 1'b0, 8'd0);
    check("ll_c0", uo_out, 8'd0);
    cmd(3'd2, 1'b0, 1'b0, 8'd1);
    check("ll_old_limit", uo_out, 8'd2);

    // LOAD_COUNT beats tick, then async reset mid-cycle
    cmd(3'd1, 1'b0, 1'b0, 8'h40);
    check("lc_beats_tick", uo_out, 8'h40);
    rst_n = 1'b0;
    #1;
    check("async_rst_count", uo_out, 8'h00);
    peek_status("async_rst_status", 8'h00);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    step(); check("post_rst_c0", uo_out, 8'd0);
    step(); check("post_rst_c0b", uo_out, 8'd0);
    peek_status("post_rst_idle", 8'h00);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
